// File: rtl/cmos_encode_v1.sv
// cmos_encode_v1: DVP camera-sensor emulator. Serialises an RGB565 pixel stream
// onto an 8-bit parallel sensor bus with pixel clock, HREF and VSYNC.
// Build macro CMOS_ENC_PATTERN_EN: when defined, an internal 8-bar colour pattern
// replaces the upstream pixels (the pix_valid_i/pix_rgb565_i inputs are ignored).
// H_ACTIVE must be a multiple of 8; all vertical region lengths must be >= 1.
module cmos_encode_v1 #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_BLANK  = 144,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BACK   = 17,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10
) (
  input  logic        cmos_clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        pix_valid_i,
  input  logic [15:0] pix_rgb565_i,
  output logic        pix_ready_o,
  output logic        cmos_pclk_o,
  output logic        cmos_href_o,
  output logic        cmos_vsync_o,
  output logic [7:0]  cmos_data_o,
  output logic        frame_done_o,
  output logic        underflow_o,
  output logic [15:0] frame_cnt_o
);

  localparam int unsigned LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned HREF_LEN = 2 * H_ACTIVE;
  localparam int unsigned XW       = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int unsigned V_MAX_A  = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
  localparam int unsigned V_MAX_B  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int unsigned V_MAX    = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
  localparam int unsigned YW       = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBACK  = 3'd2,
    S_ACTIVE = 3'd3,
    S_VFRONT = 3'd4
  } state_t;

  // Position registers describe the pclk period currently being emitted.
  state_t          r_state;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic            r_ph;

  logic            r_pix_ready;
  logic            r_href;
  logic            r_vsync;
  logic [7:0]      r_data;
  logic [7:0]      r_low;
  logic            r_frame_done;
  logic            r_underflow;
  logic [15:0]     r_frame_cnt;

  state_t          w_nxt_state;
  logic [XW-1:0]   w_nxt_x;
  logic [YW-1:0]   w_nxt_y;
  logic            w_line_end;
  logic            w_last_line;
  logic            w_nxt_href;
  logic            w_nxt_fetch;
  logic            w_nxt_frame_end;
  logic [15:0]     w_pixel;
  logic            w_starve;

  // Number of lines spent in each vertical region.
  function automatic int unsigned f_lines(input state_t s);
    int unsigned n;
    n = 1;
    case (s)
      S_VSYNC:  n = V_SYNC;
      S_VBACK:  n = V_BACK;
      S_ACTIVE: n = V_ACTIVE;
      S_VFRONT: n = V_FRONT;
      default:  n = 1;
    endcase
    return n;
  endfunction

  // Region that follows the current one; frame end re-checks the enable.
  function automatic state_t f_succ(input state_t s, input logic en);
    state_t n;
    n = S_IDLE;
    case (s)
      S_VSYNC:  n = S_VBACK;
      S_VBACK:  n = S_ACTIVE;
      S_ACTIVE: n = S_VFRONT;
      S_VFRONT: n = en ? S_VSYNC : S_IDLE;
      default:  n = S_IDLE;
    endcase
    return n;
  endfunction

  // Position of the next pclk period (x, y, region).
  always_comb begin
    w_line_end  = (32'(r_x) == LINE_LEN - 1);
    w_last_line = (32'(r_y) == f_lines(r_state) - 1);
    w_nxt_state = r_state;
    w_nxt_x     = r_x + XW'(1);
    w_nxt_y     = r_y;
    if (r_state == S_IDLE) begin
      w_nxt_x = '0;
      w_nxt_y = '0;
      if (enable_i) begin
        w_nxt_state = S_VSYNC;
      end
    end else if (w_line_end) begin
      w_nxt_x = '0;
      if (w_last_line) begin
        w_nxt_y     = '0;
        w_nxt_state = f_succ(r_state, enable_i);
      end else begin
        w_nxt_y = r_y + YW'(1);
      end
    end
  end

  // Attributes of the next pclk period.
  always_comb begin
    w_nxt_href      = (w_nxt_state == S_ACTIVE) && (32'(w_nxt_x) < HREF_LEN);
    w_nxt_fetch     = w_nxt_href && !w_nxt_x[0];
    w_nxt_frame_end = (w_nxt_state == S_VFRONT) &&
                      (32'(w_nxt_x) == LINE_LEN - 1) &&
                      (32'(w_nxt_y) == V_FRONT - 1);
  end

`ifdef CMOS_ENC_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [2:0] w_bar;
  logic       w_unused_pix;

  // Colour-bar generator indexed by the pixel position within the line.
  always_comb begin
    w_bar        = 3'((32'(w_nxt_x) >> 1) / BAR_W);
    w_starve     = 1'b0;
    w_unused_pix = pix_valid_i ^ (^pix_rgb565_i);
    w_pixel      = 16'h0000;
    case (w_bar)
      3'd0:    w_pixel = 16'hFFFF;
      3'd1:    w_pixel = 16'hFFE0;
      3'd2:    w_pixel = 16'h07FF;
      3'd3:    w_pixel = 16'h07E0;
      3'd4:    w_pixel = 16'hF81F;
      3'd5:    w_pixel = 16'hF800;
      3'd6:    w_pixel = 16'h001F;
      default: w_pixel = 16'h0000;
    endcase
  end
`else
  // Upstream pixel; a missing pixel is replaced by black and flagged.
  always_comb begin
    w_starve = !pix_valid_i;
    w_pixel  = pix_valid_i ? pix_rgb565_i : 16'h0000;
  end
`endif

  // Phase, position and all registered outputs; stream outputs move on ph 1->0.
  always_ff @(posedge cmos_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_ph         <= 1'b0;
      r_pix_ready  <= 1'b0;
      r_href       <= 1'b0;
      r_vsync      <= 1'b0;
      r_data       <= 8'h00;
      r_low        <= 8'h00;
      r_frame_done <= 1'b0;
      r_underflow  <= 1'b0;
      r_frame_cnt  <= 16'h0000;
    end else begin
      r_ph         <= ~r_ph;
      r_frame_done <= 1'b0;
      if (!r_ph) begin
        r_pix_ready <= w_nxt_fetch;
      end else begin
        r_pix_ready <= 1'b0;
        r_state     <= w_nxt_state;
        r_x         <= w_nxt_x;
        r_y         <= w_nxt_y;
        r_vsync     <= (w_nxt_state == S_VSYNC);
        r_href      <= w_nxt_href;
        if (r_pix_ready) begin
          r_data <= w_pixel[15:8];
          r_low  <= w_pixel[7:0];
          if (w_starve) begin
            r_underflow <= 1'b1;
          end
        end else if (w_nxt_href) begin
          r_data <= r_low;
        end else begin
          r_data <= 8'h00;
        end
        if (w_nxt_frame_end) begin
          r_frame_done <= 1'b1;
          r_frame_cnt  <= r_frame_cnt + 16'd1;
        end
      end
    end
  end

  assign pix_ready_o  = r_pix_ready;
  assign cmos_pclk_o  = r_ph;
  assign cmos_href_o  = r_href;
  assign cmos_vsync_o = r_vsync;
  assign cmos_data_o  = r_data;
  assign frame_done_o = r_frame_done;
  assign underflow_o  = r_underflow;
  assign frame_cnt_o  = r_frame_cnt;

endmodule

// File: tb/tb_cmos_encode_v1.sv
// Testbench for cmos_encode_v1 with a small frame geometry (22 pclk/line, 7 lines/frame).
module tb_cmos_encode_v1;

  localparam int unsigned HA      = 8;
  localparam int unsigned HB      = 6;
  localparam int unsigned VS      = 1;
  localparam int unsigned VB      = 2;
  localparam int unsigned VA      = 3;
  localparam int unsigned VF      = 1;
  localparam int unsigned LINE    = 2 * HA + HB;
  localparam int unsigned FRAME_P = LINE * (VS + VB + VA + VF);
  localparam int unsigned PPF     = HA * VA;
  localparam int unsigned NSTIM   = 64;

  typedef struct {
    logic [15:0] rgb;
    logic        valid;
    logic [7:0]  exp_hi;
    logic [7:0]  exp_lo;
    logic        exp_uf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        pix_valid = 1'b0;
  logic [15:0] pix_rgb = 16'h0000;
  logic        pix_ready, pclk, href, vsync, frame_done, underflow;
  logic [7:0]  data;
  logic [15:0] frame_cnt;
  logic [29:0] obs;

  cmos_encode_v1 #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
  ) dut (
    .cmos_clk_i   (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .pix_valid_i  (pix_valid),
    .pix_rgb565_i (pix_rgb),
    .pix_ready_o  (pix_ready),
    .cmos_pclk_o  (pclk),
    .cmos_href_o  (href),
    .cmos_vsync_o (vsync),
    .cmos_data_o  (data),
    .frame_done_o (frame_done),
    .underflow_o  (underflow),
    .frame_cnt_o  (frame_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {pix_ready, pclk, href, vsync, frame_done, underflow, data, frame_cnt};

  int          n_tests = 0;
  int          n_fail  = 0;
  int          tcyc    = 0;
  int          k       = 0;
  logic [15:0] stim_val [NSTIM];
  logic        stim_ok  [NSTIM];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, tcyc, got, exp);
    end
  endtask

  // Pixel the reference expects for stream pixel number n.
  function automatic logic [15:0] pixel_of(input int n);
`ifdef CMOS_ENC_PATTERN_EN
    logic [15:0] bars [8];
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    return bars[(n % HA) / (HA / 8)];
`else
    if (n >= NSTIM) return 16'h0000;
    return stim_ok[n] ? stim_val[n] : 16'h0000;
`endif
  endfunction

  function automatic logic src_ok(input int n);
`ifdef CMOS_ENC_PATTERN_EN
    return 1'b1;
`else
    return stim_ok[n];
`endif
  endfunction

  // Pixels consumed up to and including pclk period p (enable held high).
  function automatic int captured(input int p);
    int f, q, line, x, c;
    f = p / FRAME_P;
    q = p % FRAME_P;
    line = q / LINE;
    x = q % LINE;
    c = f * PPF;
    if (line >= VS + VB + VA) c += PPF;
    else if (line >= VS + VB) c += (line - VS - VB) * HA + ((x < 2 * HA) ? x / 2 + 1 : HA);
    return c;
  endfunction

  // Expected output bundle after the t-th clock edge following reset release,
  // with enable high throughout: frames run back to back from pclk period 0.
  function automatic logic [29:0] model(input int t);
    logic rdy, pc, hr, vs, fd, uf;
    logic [7:0] d;
    logic [15:0] fc, pv;
    int p, q, f, line, x, n, np, nq, nl, nx, cap;
    rdy = 0; pc = 0; hr = 0; vs = 0; fd = 0; uf = 0; d = 8'h00; fc = 16'h0000;
    if (t >= 1) pc = (t % 2 == 1);
    if (t >= 2) begin
      p = (t - 2) / 2;
      f = p / FRAME_P;
      q = p % FRAME_P;
      line = q / LINE;
      x = q % LINE;
      vs = (line < VS);
      hr = (line >= VS + VB) && (line < VS + VB + VA) && (x < 2 * HA);
      if (hr) begin
        n  = f * PPF + (line - VS - VB) * HA + x / 2;
        pv = pixel_of(n);
        d  = (x % 2 == 1) ? pv[7:0] : pv[15:8];
      end
      fd = (q == FRAME_P - 1) && (t % 2 == 0);
      fc = 16'((p + 1) / FRAME_P);
      cap = captured(p);
      for (int i = 0; i < cap && i < NSTIM; i++) if (!src_ok(i)) uf = 1;
    end
    if (t % 2 == 1) begin
      np = (t - 1) / 2;
      nq = np % FRAME_P;
      nl = nq / LINE;
      nx = nq % LINE;
      rdy = (nl >= VS + VB) && (nl < VS + VB + VA) && (nx < 2 * HA) && (nx % 2 == 0);
    end
    return {rdy, pc, hr, vs, fd, uf, d, fc};
  endfunction

  // One clock: advance, sample point at the falling edge, answer a ready pulse.
  task automatic tick();
    @(posedge clk);
    tcyc++;
    @(negedge clk);
    if (pix_ready) begin
      if (k < NSTIM) begin
        pix_rgb   = stim_val[k];
        pix_valid = stim_ok[k];
      end else begin
        pix_rgb   = 16'h5A5A;
        pix_valid = 1'b1;
      end
      k++;
    end else begin
      pix_rgb   = 16'($urandom);
      pix_valid = 1'($urandom);
    end
  endtask

  task automatic apply_reset(input logic en);
    @(negedge clk);
    rst = 1'b1;
    enable = en;
    pix_valid = 1'b0;
    pix_rgb = 16'h0000;
    repeat (3) @(negedge clk);
    k = 0;
    tcyc = 0;
    rst = 1'b0;
  endtask

  task automatic fill_stim(input int pct_invalid);
    for (int i = 0; i < NSTIM; i++) begin
      stim_val[i] = 16'($urandom);
      stim_ok[i]  = ($urandom_range(99) >= 32'(pct_invalid));
    end
  endtask

  initial begin
    vec_t       tbl [8];
    logic [7:0] got_b [$];
    logic       got_uf [$];
    int         fd_count, t_fd;
    logic       quiet, seen;

`ifdef CMOS_ENC_PATTERN_EN
    tbl[0] = '{16'hA5C3, 1'b1, 8'hFF, 8'hFF, 1'b0};
    tbl[1] = '{16'h1234, 1'b1, 8'hFF, 8'hE0, 1'b0};
    tbl[2] = '{16'hBEEF, 1'b0, 8'h07, 8'hFF, 1'b0};
    tbl[3] = '{16'h0F0F, 1'b1, 8'h07, 8'hE0, 1'b0};
    tbl[4] = '{16'hFFFF, 1'b1, 8'hF8, 8'h1F, 1'b0};
    tbl[5] = '{16'h0001, 1'b1, 8'hF8, 8'h00, 1'b0};
    tbl[6] = '{16'h8000, 1'b1, 8'h00, 8'h1F, 1'b0};
    tbl[7] = '{16'h7E81, 1'b1, 8'h00, 8'h00, 1'b0};
`else
    tbl[0] = '{16'hA5C3, 1'b1, 8'hA5, 8'hC3, 1'b0};
    tbl[1] = '{16'h1234, 1'b1, 8'h12, 8'h34, 1'b0};
    tbl[2] = '{16'hBEEF, 1'b0, 8'h00, 8'h00, 1'b1};
    tbl[3] = '{16'h0F0F, 1'b1, 8'h0F, 8'h0F, 1'b1};
    tbl[4] = '{16'hFFFF, 1'b1, 8'hFF, 8'hFF, 1'b1};
    tbl[5] = '{16'h0001, 1'b1, 8'h00, 8'h01, 1'b1};
    tbl[6] = '{16'h8000, 1'b1, 8'h80, 8'h00, 1'b1};
    tbl[7] = '{16'h7E81, 1'b1, 8'h7E, 8'h81, 1'b1};
`endif

    // Asynchronous reset, then idle with enable low.
    #2 rst = 1'b1;
    #1 check("reset_state", 32'(obs), 32'd0);
    repeat (3) @(negedge clk);
    tcyc = 0;
    k = 0;
    rst = 1'b0;
    quiet = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_pclk", 32'(pclk), 32'(tcyc % 2));
      quiet |= (|{pix_ready, href, vsync, frame_done, underflow, data, frame_cnt});
    end
    check("idle_quiet", 32'(quiet), 32'd0);

    // First active line decoded at pclk rise against the vector table.
    fill_stim(0);
    for (int i = 0; i < 8; i++) begin
      stim_val[i] = tbl[i].rgb;
      stim_ok[i]  = tbl[i].valid;
    end
    apply_reset(1'b1);
    for (int c = 0; c < 400 && got_b.size() < 16; c++) begin
      tick();
      if (pclk && href) begin
        got_b.push_back(data);
        got_uf.push_back(underflow);
      end
    end
    check("line_byte_count", 32'(got_b.size()), 32'd16);
    while (got_b.size() < 16) begin
      got_b.push_back(8'hxx);
      got_uf.push_back(1'bx);
    end
    for (int i = 0; i < 8; i++) begin
      check($sformatf("byte_hi[%0d]", i), 32'(got_b[2*i]), 32'(tbl[i].exp_hi));
      check($sformatf("byte_lo[%0d]", i), 32'(got_b[2*i+1]), 32'(tbl[i].exp_lo));
      check($sformatf("underflow[%0d]", i), 32'(got_uf[2*i]), 32'(tbl[i].exp_uf));
    end
    repeat (300) tick();
    check("underflow_sticky", 32'(underflow), 32'(tbl[7].exp_uf));

    // Enable dropped mid first active line: frame still completes, then idle.
    fill_stim(0);
    apply_reset(1'b1);
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      tick();
      seen = href;
    end
    check("en_href_seen", 32'(seen), 32'd1);
    repeat (3) tick();
    enable = 1'b0;
    fd_count = 0;
    t_fd = -1;
    quiet = 1'b0;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (frame_done) begin
        fd_count++;
        t_fd = tcyc;
      end else if (fd_count > 0) begin
        quiet |= (|{pix_ready, href, vsync, data});
      end
    end
    check("en_fd_count", 32'(fd_count), 32'd1);
    check("en_fd_time", 32'(t_fd), 32'(2 * FRAME_P));
    check("en_frame_cnt", 32'(frame_cnt), 32'd1);
    check("en_idle_quiet", 32'(quiet), 32'd0);

    // Reset mid-HREF in the second frame, then back-to-back frames vs. the model.
    fill_stim(0);
    apply_reset(1'b1);
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      tick();
      seen = frame_done;
    end
    check("rst_first_fd", 32'(seen), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      tick();
      seen = href;
    end
    check("rst_href_seen", 32'(seen), 32'd1);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1 check("rst_mid_href", 32'(obs), 32'd0);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      seen |= frame_done;
    end
    check("rst_no_fd", 32'(seen), 32'd0);
    fill_stim(10);
    stim_ok[30] = 1'b0;
    k = 0;
    tcyc = 0;
    rst = 1'b0;
    for (int i = 0; i < 4 * FRAME_P + 12; i++) begin
      tick();
      check("model", 32'(obs), 32'(model(tcyc)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
